// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: double-dabble, one bit per clock, one shared add-3 bank.
// Define BIN_TO_BCD_SEQ_EARLY_EXIT_EN to skip leading zeros of the operand at accept time.
module bin_to_bcd_seq #(
    parameter int W = 32,
    parameter int D = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [W-1:0]     I_DAT,
    input  logic             I_STB,
    output logic             O_RDY,
    output logic [4*D-1:0]   O_DAT,
    output logic             O_STB
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_bin;
    logic [4*D-1:0] r_bcd;
    logic [4*D-1:0] r_dat;

    logic [CW-1:0]  w_cnt_load;
    logic [W-1:0]   w_bin_load;
    logic           w_load_zero;
    logic [4*D-1:0] w_bcd_adj;
    logic [4*D-1:0] w_bcd_next;
    logic [W-1:0]   w_bin_next;
    logic           w_accept;
    logic           w_last;

`ifdef BIN_TO_BCD_SEQ_EARLY_EXIT_EN
    logic [CW-1:0]  w_msb_n;

    // Highest set bit wins: the loop overwrites lower matches.
    always_comb begin
        w_msb_n = '0;
        for (int i = 0; i < W; i++) begin
            if (I_DAT[i]) w_msb_n = CW'(i + 1);
        end
    end

    assign w_cnt_load  = w_msb_n;
    assign w_bin_load  = I_DAT << (CW'(W) - w_msb_n);
    assign w_load_zero = (w_msb_n == '0);
`else
    assign w_cnt_load  = CW'(W);
    assign w_bin_load  = I_DAT;
    assign w_load_zero = 1'b0;
`endif

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < D; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    assign {w_bcd_next, w_bin_next} = {w_bcd_adj, r_bin} << 1;

    assign O_RDY    = (r_state != SHIFT);
    assign O_STB    = (r_state == DONE);
    assign O_DAT    = r_dat;
    assign w_accept = I_STB && O_RDY;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) w_state_next = w_load_zero ? DONE : SHIFT;
                else          w_state_next = IDLE;
            end
            SHIFT: begin
                if (w_last) w_state_next = DONE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
            r_bin <= '0;
            r_bcd <= '0;
            r_dat <= '0;
        end else if (w_accept) begin
            r_bin <= w_bin_load;
            r_bcd <= '0;
            r_cnt <= w_cnt_load;
            if (w_load_zero) r_dat <= '0;
        end else if (r_state == SHIFT) begin
            r_bin <= w_bin_next;
            r_bcd <= w_bcd_next;
            r_cnt <= r_cnt - CW'(1);
            // The result register only moves on the final shift, so it holds between conversions.
            if (w_last) r_dat <= w_bcd_next;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: hand-computed BCD results, latencies, drop, back-to-back and reset abort.
// Expected latencies follow BIN_TO_BCD_SEQ_EARLY_EXIT_EN when the bench is built with it.
module tb_bin_to_bcd_seq;

    localparam int W = 32;
    localparam int D = 10;
`ifdef BIN_TO_BCD_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic           CLK   = 1'b0;
    logic           RST   = 1'b0;
    logic           I_STB = 1'b0;
    logic [W-1:0]   I_DAT = '0;
    logic           O_RDY;
    logic           O_STB;
    logic [4*D-1:0] O_DAT;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    bin_to_bcd_seq #(.W(W), .D(D)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .I_DAT (I_DAT),
        .I_STB (I_STB),
        .O_RDY (O_RDY),
        .O_DAT (O_DAT),
        .O_STB (O_STB)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns 1ns after the accepting rising edge with junk on I_DAT.
    task automatic accept(input logic [W-1:0] v);
        check("rdy_before_accept", O_RDY, 1'b1);
        I_DAT = v;
        I_STB = 1'b1;
        @(posedge CLK);
        #1;
        I_STB = 1'b0;
        I_DAT = 32'hA5A5_5A5A;
    endtask

    // lat = rising edges after the reference edge until O_STB is seen; returns on the falling edge where it is high.
    task automatic wait_stb(input string tag, output int lat, output int rdy_low);
        lat     = 0;
        rdy_low = 0;
        @(negedge CLK);
        while (!O_STB && lat < 100) begin
            if (!O_RDY) rdy_low++;
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
        check({tag, "_stb"}, O_STB, 1'b1);
    endtask

    initial begin
        int lat;
        int rl;
        int pulses;
        logic [39:0] exp_b2b [2];
        int          lat_b2b [2];

        exp_b2b[0] = 40'h0000000099;
        exp_b2b[1] = 40'h1000000000;
        lat_b2b[0] = EE ? 7 : 32;
        lat_b2b[1] = EE ? 30 : 32;

        // Reset state, with a strobe that must be ignored while reset is held
        #2;
        I_STB = 1'b1;
        I_DAT = 32'd55;
        repeat (3) @(negedge CLK);
        check("rst_rdy", O_RDY, 1'b1);
        check("rst_stb", O_STB, 1'b0);
        check("rst_dat", O_DAT, 40'h0);
        I_STB = 1'b0;
        RST   = 1'b1;
        @(negedge CLK);
        check("post_rst_rdy", O_RDY, 1'b1);
        check("post_rst_stb", O_STB, 1'b0);

        // Zero, then 12345
        accept(32'd0);
        wait_stb("zero", lat, rl);
        check("zero_lat", lat, EE ? 0 : 32);
        check("zero_dat", O_DAT, 40'h0000000000);
        @(negedge CLK);
        check("idle_stb_low", O_STB, 1'b0);

        accept(32'd12345);
        wait_stb("d12345", lat, rl);
        check("d12345_lat", lat, EE ? 14 : 32);
        check("d12345_dat", O_DAT, 40'h0000012345);

        // All ones, accepted straight out of DONE
        accept(32'hFFFF_FFFF);
        wait_stb("max", lat, rl);
        check("max_lat", lat, 32);
        check("max_rdy_low", rl, 32);
        check("max_rdy_done", O_RDY, 1'b1);
        check("max_dat", O_DAT, 40'h4294967295);

        accept(32'd5);
        wait_stb("d5", lat, rl);
        check("d5_lat", lat, EE ? 3 : 32);
        check("d5_dat", O_DAT, 40'h0000000005);

        accept(32'h8000_0000);
        wait_stb("p31", lat, rl);
        check("p31_lat", lat, 32);
        check("p31_dat", O_DAT, 40'h2147483648);

        // Back-to-back with I_STB held high, alternating 99 and 1000000000
        @(negedge CLK);
        I_DAT = 32'd99;
        I_STB = 1'b1;
        @(posedge CLK);
        for (int k = 0; k < 4; k++) begin
            #1;
            I_DAT = (k % 2 == 0) ? 32'd1000000000 : 32'd99;
            wait_stb("b2b", lat, rl);
            check("b2b_lat", lat, lat_b2b[k % 2]);
            check("b2b_dat", O_DAT, exp_b2b[k % 2]);
            @(posedge CLK);
        end
        #1;
        I_STB = 1'b0;
        wait_stb("b2b_last", lat, rl);
        check("b2b_last_lat", lat, lat_b2b[0]);
        check("b2b_last_dat", O_DAT, exp_b2b[0]);

        // Strobe of 777 during a conversion of 42 is dropped
        @(negedge CLK);
        accept(32'd42);
        repeat (4) @(negedge CLK);
        I_DAT = 32'd777;
        I_STB = 1'b1;
        @(posedge CLK);
        #1;
        I_STB = 1'b0;
        I_DAT = 32'd0;
        wait_stb("drop", lat, rl);
        check("drop_lat", lat, EE ? 2 : 28);
        check("drop_dat", O_DAT, 40'h0000000042);
        pulses = 0;
        repeat (40) begin
            @(negedge CLK);
            if (O_STB) pulses++;
        end
        check("drop_no_extra_stb", pulses, 0);
        check("drop_dat_held", O_DAT, 40'h0000000042);

        // Reset in cycle 10 of a conversion of 65535 aborts it
        accept(32'd65535);
        repeat (9) @(negedge CLK);
        RST   = 1'b0;
        I_STB = 1'b1;
        I_DAT = 32'd123;
        #1;
        check("abort_rdy", O_RDY, 1'b1);
        check("abort_stb", O_STB, 1'b0);
        check("abort_dat", O_DAT, 40'h0);
        repeat (2) @(negedge CLK);
        check("abort_hold_dat", O_DAT, 40'h0);
        I_STB = 1'b0;
        RST   = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge CLK);
            if (O_STB) pulses++;
        end
        check("abort_no_stb", pulses, 0);
        check("abort_dat_after", O_DAT, 40'h0);
        check("abort_rdy_after", O_RDY, 1'b1);

        accept(32'd8);
        wait_stb("d8", lat, rl);
        check("d8_lat", lat, EE ? 4 : 32);
        check("d8_dat", O_DAT, 40'h0000000008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter W, default 32: binary input width in bits.
REQ-002 SHALL have parameter D, default 10: BCD output digit count; legal only when 10^D > 2^W - 1.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port I_DAT, input, W bits: unsigned binary operand, sampled only on the accepting edge.
REQ-006 SHALL have port I_STB, input, 1 bit: request strobe.
REQ-007 SHALL have port O_RDY, output, 1 bit: block can accept I_STB this cycle.
REQ-008 SHALL have port O_DAT, output, 4*D bits: packed BCD result, digit 0 in bits [3:0], and each higher digit 4 bits above the previous one.
REQ-009 SHALL have port O_STB, output, 1 bit: one-cycle result-valid pulse.

Function
REQ-010 SHALL implement iterative shift-add-3 (double-dabble) conversion, one bit per clock, with one shared add-3 bank for all D digits.
REQ-011 SHALL use FSM states IDLE, SHIFT and DONE.
REQ-012 SHALL drive O_RDY=1 in IDLE and DONE, and O_RDY=0 in SHIFT.
REQ-013 SHALL perform an accepting edge (E0) when I_STB=1 and O_RDY=1, which loads I_DAT into the binary shift register, clears the BCD accumulator, sets the bit counter to W and enters SHIFT.
REQ-014 SHALL, on each edge in SHIFT, add 3 to every BCD digit ≥5, then shift {BCD,binary} left by 1 and decrement the counter.
REQ-015 SHALL, on the edge where the counter reaches 0 (E_W), copy the accumulator to O_DAT and enter DONE.
REQ-016 SHALL assert O_STB for exactly the one cycle spent in DONE, so it is high in the cycle after E_W (W cycles after E0).
REQ-017 SHALL, on the edge leaving DONE, go to SHIFT if I_STB=1 (new accept) or otherwise to IDLE; back-to-back throughput is one result per W+1 clocks.
REQ-018 SHALL ignore I_STB while O_RDY=0; the request is dropped, not queued, and I_DAT is not sampled.
REQ-019 SHALL hold O_DAT stable from one result until the next E_W, and leave it unchanged by accepts and SHIFT activity.
REQ-020 SHALL produce exact decimal results for every input 0 .. 2^W-1 with no overflow, saturation or error indication.
REQ-021 SHALL ignore I_DAT changes after E0.

Reset
REQ-022 SHALL, while RST=0, asynchronously force state=IDLE, counter=0, shift registers=0, O_DAT=0, O_STB=0 and O_RDY=1.
REQ-023 SHALL treat a reset asserted mid-SHIFT as an abort: no O_STB is issued for the aborted request, and O_DAT reads 0.
REQ-024 SHALL ignore I_STB while RST=0; the first possible accept is on the first rising edge after RST deasserts.

Configuration
REQ-025 SHALL use macro BIN_TO_BCD_SEQ_EARLY_EXIT_EN to compile in leading-zero skipping.
REQ-026 SHALL, when the macro is defined, at E0 left-align I_DAT to its most significant 1 and load the counter with N = index of that bit + 1, giving O_STB N cycles after E0.
REQ-027 SHALL, when the macro is defined and I_DAT=0, go directly from E0 to DONE with O_DAT=0, so O_STB is high in the cycle after E0.
REQ-028 SHALL, when the macro is undefined, use a fixed latency of W for all inputs and contain no priority-encoder logic.
REQ-029 SHALL keep REQ-012..REQ-024 unchanged in both configurations except for latency.

Verification
REQ-030 Bench SHALL cover: I_DAT=0 then 12345 (macro off) -> O_STB 32 cycles after each accept, O_DAT=0x0000000000 then 0x0000012345.
REQ-031 Bench SHALL cover: I_DAT=4294967295 -> O_DAT=0x4294967295, and O_RDY=0 for 32 cycles after E0.
REQ-032 Bench SHALL cover: I_STB held high continuously, alternating 99 and 1000000000 -> accepts in DONE, results 0x0000000099 and 0x1000000000, with O_STB pulses every 33 cycles.
REQ-033 Bench SHALL cover: I_STB=1 with I_DAT=777 at cycle 5 of a conversion of 42 -> 777 dropped, only 0x0000000042 returned, O_DAT held afterward.
REQ-034 Bench SHALL cover: RST low at cycle 10 of a conversion of 65535 -> O_STB never pulses, O_DAT=0, O_RDY=1; after release, a new accept of 8 yields 0x0000000008.
REQ-035 Bench SHALL cover (macro on): I_DAT=5 -> O_STB 3 cycles after E0 with 0x0000000005; I_DAT=0 -> O_STB 1 cycle after E0 with O_DAT=0; 2^31 -> 32 cycles, result 0x2147483648.
